// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector:
// state width, default pattern, and the KMP fallback / next-state table builders.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Pattern bit i in arrival order is pat[len-1-i]; both helpers index that way.
  // F(k): longest proper prefix of the first k pattern bits that is also their suffix.
  function automatic int fail_of(input logic [15:0] pat, input int len, input int k);
    int  best;
    logic ok;
    best = 0;
    for (int l = 1; l < k; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        if (pat[len-1-j] != pat[len-1-(k-l+j)]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Longest pattern prefix (shorter than len) that ends the history "first s bits, then b".
  function automatic int next_of(input logic [15:0] pat, input int len, input int s,
                                 input logic b);
    int   best;
    logic ok;
    logic t;
    best = 0;
    for (int l = 1; (l <= s + 1) && (l < len); l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        t = ((s + 1 - l + j) < s) ? pat[len-1-(s+1-l+j)] : b;
        if (pat[len-1-j] != t) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating, synchronously clearable match counter used by seq_detector.
module seq_det_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear beats a simultaneous increment.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial LEN-bit pattern detector with KMP fallback and run-time overlap select.
// Define SEQ_DET_COUNT_EN to add count_clr / match_count and the saturating counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(DEFAULT_PATTERN),
  parameter int             CNT_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset_b,
  input  logic                      en,
  input  logic                      in_bit,
  input  logic                      overlap,
`ifdef SEQ_DET_COUNT_EN
  input  logic                      count_clr,
  output logic [CNT_W-1:0]          match_count,
`endif
  output logic                      match,
  output logic [state_w(LEN)-1:0]   state_dbg
);

  localparam int SW    = state_w(LEN);
  localparam int F_LEN = fail_of(16'(PATTERN), LEN, LEN);

  logic [SW-1:0] state_q, state_d;
  logic          match_d;
  logic          hit;
  logic [SW-1:0] nxt_tab [2**SW][2];

  // Constant transition table; rows past LEN-1 are unreachable and tied to 0.
  for (genvar s = 0; s < 2**SW; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      if (s < LEN) begin : g_valid
        assign nxt_tab[s][b] = SW'(next_of(16'(PATTERN), LEN, s, 1'(b)));
      end else begin : g_unused
        assign nxt_tab[s][b] = '0;
      end
    end
  end

  // en qualifies in_bit each cycle; there is no backpressure, a sample with en=0 is ignored.
  assign hit = (state_q == SW'(LEN - 1)) && (in_bit == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (en) begin
      if (hit) begin
        match_d = 1'b1;
        state_d = overlap ? SW'(F_LEN) : '0;
      end else begin
        state_d = nxt_tab[state_q][in_bit];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_q <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      match   <= match_d;
    end
  end

  assign state_dbg = state_q;

`ifdef SEQ_DET_COUNT_EN
  seq_det_counter #(.CNT_W(CNT_W)) u_counter (
    .clock   (clock),
    .reset_b (reset_b),
    .inc     (match_d),
    .clr     (count_clr),
    .count   (match_count)
  );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector (LEN=4, PATTERN=1011, CNT_W=2): table vectors
// plus hand sequences for enable gaps, mid-pattern reset and counter saturation/clear.
module tb_seq_detector;

  localparam int             LEN     = 4;
  localparam logic [LEN-1:0] PATTERN = 4'b1011;
  localparam int             CNT_W   = 2;
  localparam int             SW      = $clog2(LEN + 1);

  logic          clock   = 1'b0;
  logic          reset_b = 1'b0;
  logic          en      = 1'b0;
  logic          in_bit  = 1'b0;
  logic          overlap = 1'b0;
  logic          match;
  logic [SW-1:0] state_dbg;
`ifdef SEQ_DET_COUNT_EN
  logic             count_clr = 1'b0;
  logic [CNT_W-1:0] match_count;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic             rb;
    logic             e;
    logic             b;
    logic             o;
    logic             clr;
    logic             m;
    logic [SW-1:0]    s;
    logic [CNT_W-1:0] c;
  } vec_t;

  vec_t vecs[$];

  seq_detector #(.LEN(LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_b     (reset_b),
    .en          (en),
    .in_bit      (in_bit),
    .overlap     (overlap),
`ifdef SEQ_DET_COUNT_EN
    .count_clr   (count_clr),
    .match_count (match_count),
`endif
    .match       (match),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step(input logic rb, input logic e, input logic b, input logic o);
    reset_b = rb;
    en      = e;
    in_bit  = b;
    overlap = o;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic rb, input logic e, input logic b, input logic o,
                     input logic clr, input logic m, input int s, input int c);
    vec_t v;
    v.rb = rb; v.e = e; v.b = b; v.o = o; v.clr = clr; v.m = m;
    v.s  = SW'(s);
    v.c  = CNT_W'(c);
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] pat_bits;
    int         n_match;

    // Reset with toggling data and en=1.
    add(0,1,1,0,0, 0,0,0);
    add(0,1,0,0,0, 0,0,0);
    add(0,1,1,0,0, 0,0,0);
    // Non-overlap: 1,0,1,1,0,1,1 -> one match after bit 4.
    add(1,1,1,0,0, 0,1,0);
    add(1,1,0,0,0, 0,2,0);
    add(1,1,1,0,0, 0,3,0);
    add(1,1,1,0,0, 1,0,1);
    add(1,1,0,0,0, 0,0,1);
    add(1,1,1,0,0, 0,1,1);
    add(1,1,1,0,0, 0,1,1);
    add(0,1,0,0,0, 0,0,0);
    // Overlap: same stream -> matches after bits 4 and 7, F(4)=1.
    add(1,1,1,1,0, 0,1,0);
    add(1,1,0,1,0, 0,2,0);
    add(1,1,1,1,0, 0,3,0);
    add(1,1,1,1,0, 1,1,1);
    add(1,1,0,1,0, 0,2,1);
    add(1,1,1,1,0, 0,3,1);
    add(1,1,1,1,0, 1,1,2);
    add(0,1,0,0,0, 0,0,0);
    // KMP fallback: 1,0,1,0,1,0,1,1 -> states 1,2,3,2,3,2,3 then match.
    add(1,1,1,0,0, 0,1,0);
    add(1,1,0,0,0, 0,2,0);
    add(1,1,1,0,0, 0,3,0);
    add(1,1,0,0,0, 0,2,0);
    add(1,1,1,0,0, 0,3,0);
    add(1,1,0,0,0, 0,2,0);
    add(1,1,1,0,0, 0,3,0);
    add(1,1,1,0,0, 1,0,1);
    // en=0 right after a match drops the pulse and holds state.
    add(1,0,1,0,0, 0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
`ifdef SEQ_DET_COUNT_EN
      count_clr = vecs[i].clr;
`endif
      step(vecs[i].rb, vecs[i].e, vecs[i].b, vecs[i].o);
      check("vec_match", i, 16'(match), 16'(vecs[i].m));
      check("vec_state", i, 16'(state_dbg), 16'(vecs[i].s));
`ifdef SEQ_DET_COUNT_EN
      check("vec_count", i, 16'(match_count), 16'(vecs[i].c));
`endif
    end

    // Enable gaps: state must hold through 5 idle cycles between bits.
    pat_bits = 4'b1011;
    step(0,1,0,0);
    for (int i = 0; i < 4; i++) begin
      step(1,1,pat_bits[3-i],0);
      if (i < 3) begin
        check("gap_state", i, 16'(state_dbg), 16'(i + 1));
        check("gap_match", i, 16'(match), 16'd0);
        for (int g = 0; g < 5; g++) begin
          step(1,0,g[0],0);
          check("gap_hold", i*8 + g, 16'(state_dbg), 16'(i + 1));
          check("gap_hold_match", i*8 + g, 16'(match), 16'd0);
        end
      end else begin
        check("gap_final_match", i, 16'(match), 16'd1);
        check("gap_final_state", i, 16'(state_dbg), 16'd0);
      end
    end

    // Reset mid-pattern discards the partial match.
    step(1,1,1,0);
    step(1,1,0,0);
    step(1,1,1,0);
    check("midrst_pre", 0, 16'(state_dbg), 16'd3);
    step(0,1,1,0);
    check("midrst_state", 0, 16'(state_dbg), 16'd0);
    check("midrst_match", 0, 16'(match), 16'd0);
    step(1,1,1,0);
    check("midrst_after_state", 0, 16'(state_dbg), 16'd1);
    check("midrst_after_match", 0, 16'(match), 16'd0);

`ifdef SEQ_DET_COUNT_EN
    // Saturation: 1011 then 011 x4 in overlap mode gives 5 matches; count caps at 3.
    step(0,1,0,1);
    n_match = 0;
    for (int i = 0; i < 16; i++) begin
      step(1,1,(i == 0) ? 1'b1 : ((i % 3) != 1),1);
      if (match === 1'b1) n_match++;
    end
    check("sat_pulses", 0, 16'(n_match), 16'd5);
    check("sat_count", 0, 16'(match_count), 16'd3);
    check("sat_state", 0, 16'(state_dbg), 16'd1);
    // Clear on the same edge as a match: count 0, match still pulses.
    step(1,1,0,1);
    step(1,1,1,1);
    count_clr = 1'b1;
    step(1,1,1,1);
    count_clr = 1'b0;
    check("clr_match", 0, 16'(match), 16'd1);
    check("clr_count", 0, 16'(match_count), 16'd0);
    step(1,0,0,1);
    check("clr_hold_count", 0, 16'(match_count), 16'd0);
`else
    n_match = 0;
    check("nocnt_idle", 0, 16'(match) + 16'(n_match), 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
